// File: rtl/led_blink_stretcher.sv
// led_blink_stretcher
//   Stretches short event pulses into visible LED blinks separated by a forced dark gap.
//   Events that arrive while a blink or gap is in progress are counted (saturating) and
//   replayed later as separate blinks. Brightness during a blink comes from a free-running PWM.
//
// Ports
//   i_Clk       system clock
//   i_Rst_L     asynchronous active-low reset
//   i_Event     event request, each rising edge is one event
//   i_Level     PWM brightness, 0 = dark, all-ones = fully on
//   i_Clear     one-cycle pulse clearing o_Overflow
//   o_LED       registered LED drive
//   o_Busy      high while a blink or its gap is in progress
//   o_Pending   queued events not yet blinked
//   o_Overflow  sticky flag, an event was dropped with the queue full
module led_blink_stretcher #(
    parameter int unsigned c_ON_CYCLES  = 2500000,
    parameter int unsigned c_GAP_CYCLES = 2500000,
    parameter int unsigned c_PEND_MAX   = 7,
    parameter int unsigned c_PWM_BITS   = 4
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_L,
    input  logic                  i_Event,
    input  logic [c_PWM_BITS-1:0] i_Level,
    input  logic                  i_Clear,
    output logic                  o_LED,
    output logic                  o_Busy,
    output logic [2:0]            o_Pending,
    output logic                  o_Overflow
);

    localparam int unsigned c_TMAX = (c_ON_CYCLES > c_GAP_CYCLES) ? c_ON_CYCLES : c_GAP_CYCLES;
    localparam int unsigned c_TW   = $clog2(c_TMAX + 1);

    localparam logic [c_TW-1:0] c_ON_LOAD  = c_TW'(c_ON_CYCLES - 1);
    localparam logic [c_TW-1:0] c_GAP_LOAD = c_TW'(c_GAP_CYCLES - 1);
    localparam logic [2:0]      c_PEND_LIM = 3'(c_PEND_MAX);

    typedef enum logic [1:0] {
        StIdle,
        StOn,
        StGap
    } state_e;

    state_e                  state_q, state_d;
    logic [c_TW-1:0]         timer_q, timer_d;
    logic [c_PWM_BITS-1:0]   pwm_q, pwm_d;
    logic [2:0]              pending_q, pending_d;
    logic                    overflow_q, overflow_d;
    logic                    event_prev_q, event_prev_d;
    logic                    led_q, led_d;
    logic                    busy_q, busy_d;

    logic ev;
    logic timer_zero;
    logic dequeue;
    logic enqueue_req;
    logic drop;

    assign ev         = i_Event & ~event_prev_q;
    assign timer_zero = (timer_q == '0);

    // Blink sequencer
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        dequeue = 1'b0;
        case (state_q)
            StIdle: begin
                if (ev) begin
                    state_d = StOn;
                    timer_d = c_ON_LOAD;
                end
            end
            StOn: begin
                if (timer_zero) begin
                    state_d = StGap;
                    timer_d = c_GAP_LOAD;
                end else begin
                    timer_d = timer_q - c_TW'(1);
                end
            end
            StGap: begin
                if (timer_zero) begin
                    if (pending_q != 3'd0) begin
                        state_d = StOn;
                        timer_d = c_ON_LOAD;
                        dequeue = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    timer_d = timer_q - c_TW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                timer_d = '0;
            end
        endcase
    end

    // Event queue. An event that lands on the same cycle as a dequeue always fits, since
    // the slot it needs is being freed; the two cancel and the count holds.
    always_comb begin
        enqueue_req = ev && (state_q != StIdle);
        pending_d   = pending_q;
        drop        = 1'b0;
        if (enqueue_req && dequeue) begin
            pending_d = pending_q;
        end else if (enqueue_req) begin
            if (pending_q < c_PEND_LIM) begin
                pending_d = pending_q + 3'd1;
            end else begin
                drop = 1'b1;
            end
        end else if (dequeue) begin
            pending_d = pending_q - 3'd1;
        end
    end

    // Setting the flag takes priority over a simultaneous clear.
    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (i_Clear) begin
            overflow_d = 1'b0;
        end
    end

    // Output drive; all-ones level forces the LED fully on instead of 2^n-1 / 2^n duty.
    always_comb begin
        pwm_d        = pwm_q + c_PWM_BITS'(1);
        event_prev_d = i_Event;
        busy_d       = (state_q != StIdle);
        led_d        = 1'b0;
        if (state_q == StOn) begin
            led_d = (i_Level == '1) || (pwm_q < i_Level);
        end
    end

    // Edge register resets high so an input already asserted at reset release is ignored.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            pwm_q        <= '0;
            pending_q    <= 3'd0;
            overflow_q   <= 1'b0;
            event_prev_q <= 1'b1;
            led_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            pwm_q        <= pwm_d;
            pending_q    <= pending_d;
            overflow_q   <= overflow_d;
            event_prev_q <= event_prev_d;
            led_q        <= led_d;
            busy_q       <= busy_d;
        end
    end

    assign o_LED      = led_q;
    assign o_Busy     = busy_q;
    assign o_Pending  = pending_q;
    assign o_Overflow = overflow_q;

endmodule
